utmi_phy_model: RTL



---
 rtl/utmi_pkg.sv | 22 ++
 rtl/utmi_phy_model_if.sv | 39 +++
 rtl/utmi_phy_rx_fifo.sv | 44 ++++
 rtl/utmi_phy_model.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/utmi_pkg.sv
// Shared types and encodings for the UTMI PHY model: OpMode/LineState codes,
// TX/RX FSM state enums and the RX FIFO entry layout.
package utmi_pkg;

  localparam logic [1:0] OPM_NORMAL  = 2'b00;
  localparam logic [1:0] OPM_NONDRV  = 2'b01;
  localparam logic [1:0] OPM_NOSTUFF = 2'b10;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;

  typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_EOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_EOP} rx_state_e;

  // "last" marks the final byte of a packet; err turns that entry into an error terminator
  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/utmi_phy_model_if.sv
// UTMI link-facing signals plus the byte-level bus side used by the environment.
// master = link/environment side, slave = PHY model.
interface utmi_phy_model_if;
  logic [7:0] DataOut_o;
  logic       TxValid_o;
  logic       TxReady_i;
  logic [7:0] DataIn_i;
  logic       RxValid_i;
  logic       RxActive_i;
  logic       RxError_i;
  logic       XcvSelect_o;
  logic       TermSel_o;
  logic       SuspendM_o;
  logic [1:0] OpMode_o;
  logic [1:0] LineState_i;
  logic [7:0] tx_byte;
  logic       tx_byte_vld;
  logic       tx_pkt_end;
  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic       rx_pkt_end;
  logic       rx_err_inj;
  logic       rx_fifo_full;
  logic       rx_ovf;

  modport master (
    output DataOut_o, TxValid_o, XcvSelect_o, TermSel_o, SuspendM_o, OpMode_o,
    output rx_byte, rx_byte_vld, rx_pkt_end, rx_err_inj,
    input  TxReady_i, DataIn_i, RxValid_i, RxActive_i, RxError_i, LineState_i,
    input  tx_byte, tx_byte_vld, tx_pkt_end, rx_fifo_full, rx_ovf
  );

  modport slave (
    input  DataOut_o, TxValid_o, XcvSelect_o, TermSel_o, SuspendM_o, OpMode_o,
    input  rx_byte, rx_byte_vld, rx_pkt_end, rx_err_inj,
    output TxReady_i, DataIn_i, RxValid_i, RxActive_i, RxError_i, LineState_i,
    output tx_byte, tx_byte_vld, tx_pkt_end, rx_fifo_full, rx_ovf
  );
endinterface

// File: rtl/utmi_phy_rx_fifo.sv
// Single-clock FIFO with show-ahead read data; 1-cycle push-to-pop latency.
// Pushes while full and pops while empty are ignored; simultaneous push/pop keeps count.
module utmi_phy_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/utmi_phy_model.sv
// PHY-side UTMI model: accepts link TX bytes and replays injected RX packets to the link.
// TX byte reported 1 cycle after acceptance; TxReady drops for SYNC, bit-stuff gaps and RX activity.
module utmi_phy_model
  import utmi_pkg::*;
#(
  parameter int TX_READY_GAP  = 6,
  parameter int RX_START_DLY  = 3,
  parameter int RX_EOP_DLY    = 2,
  parameter int RX_FIFO_DEPTH = 16
) (
  input logic             utmi_clk,
  input logic             utmi_rst,
  utmi_phy_model_if.slave bus
);
  localparam int CNT_W = $clog2(RX_FIFO_DEPTH) + 1;
  localparam logic [7:0] GAP_LAST   = 8'(TX_READY_GAP - 1);
  localparam logic [7:0] START_LAST = 8'(RX_START_DLY - 1);
  localparam logic [7:0] EOP_LAST   = 8'(RX_EOP_DLY - 1);

  tx_state_e        tx_q, tx_d;
  rx_state_e        rx_q, rx_d;
  logic             tx_cnt_q, tx_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d, rx_cnt_q, rx_cnt_d;
  logic             gap_pause_q, gap_pause_d, nostuff_q, nostuff_d;
  logic             tx_start, rx_start, tx_ready, tx_accept, gap_en;
  logic             fifo_pop, fifo_full, fifo_empty, rx_vld, rx_err;
  logic [CNT_W-1:0] fifo_cnt;
  rx_entry_t        push_ent, head;
  logic [7:0]       tx_byte_q;
  logic             tx_byte_vld_q, tx_pkt_end_q, rx_ovf_q;
  logic [1:0]       ls_q, ls_d;

  assign push_ent = '{err: bus.rx_err_inj & bus.rx_pkt_end, last: bus.rx_pkt_end, data: bus.rx_byte};

  utmi_phy_rx_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk(utmi_clk), .rst_n(utmi_rst), .push(bus.rx_byte_vld), .push_dat(push_ent),
    .pop(fifo_pop), .pop_dat(head), .full(fifo_full), .empty(fifo_empty), .count(fifo_cnt)
  );

  // TX has priority: RX may only leave idle when TX is idle and not starting now
  assign tx_start  = (tx_q == TX_IDLE) && bus.TxValid_o && (bus.OpMode_o != OPM_NONDRV)
                     && bus.SuspendM_o && (rx_q == RX_IDLE);
  assign rx_start  = (rx_q == RX_IDLE) && !fifo_empty && (tx_q == TX_IDLE) && !tx_start
                     && bus.SuspendM_o;
  assign tx_ready  = (tx_q == TX_DATA) && !gap_pause_q;
  assign tx_accept = bus.TxValid_o && tx_ready;
  assign gap_en    = (TX_READY_GAP != 0) && !nostuff_q;

  always_comb begin
    tx_d        = tx_q;
    tx_cnt_d    = tx_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    gap_pause_d = 1'b0;
    nostuff_d   = nostuff_q;
    case (tx_q)
      TX_IDLE: if (tx_start) begin
        tx_d      = TX_SYNC;
        tx_cnt_d  = 1'b0;
        gap_cnt_d = '0;
        nostuff_d = (bus.OpMode_o == OPM_NOSTUFF);
      end
      TX_SYNC: begin
        tx_cnt_d = ~tx_cnt_q;
        if (!bus.TxValid_o) begin
          tx_d     = TX_EOP;
          tx_cnt_d = 1'b0;
        end else if (tx_cnt_q) begin
          tx_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (!bus.TxValid_o) begin
          tx_d     = TX_EOP;
          tx_cnt_d = 1'b0;
        end else if (tx_accept) begin
          if (gap_en && gap_cnt_q == GAP_LAST) begin
            gap_pause_d = 1'b1;
            gap_cnt_d   = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
      end
      TX_EOP: begin
        tx_cnt_d = ~tx_cnt_q;
        if (tx_cnt_q) tx_d = TX_IDLE;
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_d     = rx_q;
    rx_cnt_d = rx_cnt_q;
    fifo_pop = 1'b0;
    rx_vld   = 1'b0;
    rx_err   = 1'b0;
    case (rx_q)
      RX_IDLE: if (rx_start) begin
        rx_d     = RX_START;
        rx_cnt_d = '0;
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + 8'd1;
        if (rx_cnt_q == START_LAST) rx_d = RX_DATA;
      end
      RX_DATA: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        rx_err   = head.err;
        rx_vld   = !head.err;
        rx_cnt_d = '0;
        if (head.err || head.last) rx_d = RX_EOP;
      end
      RX_EOP: begin
        rx_cnt_d = rx_cnt_q + 8'd1;
        if (rx_cnt_q == EOP_LAST) rx_d = RX_IDLE;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // Line state is registered from next state so it tracks the FSMs and is 0 in reset
  always_comb begin
    ls_d = LS_SE0;
    if (tx_d == TX_EOP || rx_d == RX_EOP)                          ls_d = LS_SE0;
    else if (tx_d != TX_IDLE || rx_d != RX_IDLE || !bus.SuspendM_o) ls_d = LS_J;
    else                                                           ls_d = bus.XcvSelect_o ? LS_J : LS_SE0;
  end

  always_ff @(posedge utmi_clk or negedge utmi_rst) begin
    if (!utmi_rst) begin
      tx_q          <= TX_IDLE;
      rx_q          <= RX_IDLE;
      tx_cnt_q      <= 1'b0;
      gap_cnt_q     <= '0;
      gap_pause_q   <= 1'b0;
      nostuff_q     <= 1'b0;
      rx_cnt_q      <= '0;
      tx_byte_q     <= '0;
      tx_byte_vld_q <= 1'b0;
      tx_pkt_end_q  <= 1'b0;
      rx_ovf_q      <= 1'b0;
      ls_q          <= LS_SE0;
    end else begin
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      tx_cnt_q      <= tx_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      gap_pause_q   <= gap_pause_d;
      nostuff_q     <= nostuff_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_byte_vld_q <= tx_accept;
      if (tx_accept) tx_byte_q <= bus.DataOut_o;
      tx_pkt_end_q  <= (tx_d == TX_EOP) && (tx_q != TX_EOP);
      rx_ovf_q      <= bus.rx_byte_vld && fifo_full;
      ls_q          <= ls_d;
    end
  end

  assign bus.TxReady_i    = tx_ready;
  assign bus.DataIn_i     = rx_vld ? head.data : 8'h00;
  assign bus.RxValid_i    = rx_vld;
  assign bus.RxActive_i   = (rx_q != RX_IDLE);
  assign bus.RxError_i    = rx_err;
  assign bus.LineState_i  = ls_q;
  assign bus.tx_byte      = tx_byte_q;
  assign bus.tx_byte_vld  = tx_byte_vld_q;
  assign bus.tx_pkt_end   = tx_pkt_end_q;
  assign bus.rx_fifo_full = (fifo_cnt == CNT_W'(RX_FIFO_DEPTH));
  assign bus.rx_ovf       = rx_ovf_q;
endmodule
